// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: encodings, state
// and instruction-class enums, datapath select codes, and the instruction classifier.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;
    localparam logic [1:0] ALU_LUI  = 2'b11;

    localparam logic [1:0] GPR_RT   = 2'b00;
    localparam logic [1:0] GPR_RD   = 2'b01;
    localparam logic [1:0] GPR_RA   = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    typedef enum logic [3:0] {
        FETCH = 4'd0,
        DCD   = 4'd1,
        MA    = 4'd2,
        MR    = 4'd3,
        MWB   = 4'd4,
        MW    = 4'd5,
        EXE   = 4'd6,
        ALUWB = 4'd7,
        BR    = 4'd8,
        JMP   = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        CL_ILL  = 4'd0,
        CL_ADDU = 4'd1,
        CL_SUBU = 4'd2,
        CL_JR   = 4'd3,
        CL_ORI  = 4'd4,
        CL_LUI  = 4'd5,
        CL_LW   = 4'd6,
        CL_SW   = 4'd7,
        CL_BEQ  = 4'd8,
        CL_J    = 4'd9,
        CL_JAL  = 4'd10
    } instr_e;

    // Collapses op/funct into one class so the FSM never re-decodes raw fields.
    function automatic instr_e classify(input logic [5:0] op, input logic [5:0] funct);
        instr_e cls;
        cls = CL_ILL;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls = CL_ADDU;
                    FN_SUBU: cls = CL_SUBU;
                    FN_JR:   cls = CL_JR;
                    default: cls = CL_ILL;
                endcase
            end
            OP_ORI:  cls = CL_ORI;
            OP_LUI:  cls = CL_LUI;
            OP_LW:   cls = CL_LW;
            OP_SW:   cls = CL_SW;
            OP_BEQ:  cls = CL_BEQ;
            OP_J:    cls = CL_J;
            OP_JAL:  cls = CL_JAL;
            default: cls = CL_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: a single state register plus a Moore output
// decode of state and the IR op/funct fields that drives datapath selects and enables.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       rf_wr,
    output logic       dm_wr,
    output logic       ext_op,
    output logic [1:0] alu_op,
    output logic       b_sel,
    output logic [1:0] gpr_sel,
    output logic [1:0] wd_sel,
    output logic [1:0] npc_op,
    output logic       instr_done,
    output logic       illegal
);

    state_e state_q;
    state_e state_d;
    instr_e cls;

    assign cls = classify(op, funct);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DCD;
            DCD: begin
                case (cls)
                    CL_LW, CL_SW:                    state_d = MA;
                    CL_ADDU, CL_SUBU, CL_ORI, CL_LUI: state_d = EXE;
                    CL_BEQ:                          state_d = BR;
                    CL_J, CL_JAL, CL_JR:             state_d = JMP;
                    default:                         state_d = FETCH;
                endcase
            end
            MA: begin
                if (cls == CL_LW) begin
                    state_d = MR;
                end else if (cls == CL_SW) begin
                    state_d = MW;
                end else begin
                    state_d = FETCH;
                end
            end
            MR:      state_d = MWB;
            EXE:     state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    // Reset gates every output combinationally so no write can land in the reset cycle.
    always_comb begin
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        rf_wr      = 1'b0;
        dm_wr      = 1'b0;
        ext_op     = 1'b0;
        alu_op     = ALU_ADD;
        b_sel      = 1'b0;
        gpr_sel    = GPR_RT;
        wd_sel     = WD_ALU;
        npc_op     = NPC_PC4;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    pc_wr = 1'b1;
                    ir_wr = 1'b1;
                end
                DCD: begin
                    if (cls == CL_ILL) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                MA: begin
                    b_sel  = 1'b1;
                    ext_op = 1'b1;
                end
                MWB: begin
                    rf_wr      = 1'b1;
                    wd_sel     = WD_DM;
                    instr_done = 1'b1;
                end
                MW: begin
                    dm_wr      = 1'b1;
                    b_sel      = 1'b1;
                    ext_op     = 1'b1;
                    instr_done = 1'b1;
                end
                EXE, ALUWB: begin
                    case (cls)
                        CL_SUBU: alu_op = ALU_SUB;
                        CL_ORI: begin
                            alu_op = ALU_OR;
                            b_sel  = 1'b1;
                        end
                        CL_LUI: begin
                            alu_op = ALU_LUI;
                            b_sel  = 1'b1;
                        end
                        default: alu_op = ALU_ADD;
                    endcase
                    if (state_q == ALUWB) begin
                        rf_wr      = 1'b1;
                        instr_done = 1'b1;
                        gpr_sel    = (cls == CL_ADDU || cls == CL_SUBU) ? GPR_RD : GPR_RT;
                    end
                end
                BR: begin
                    alu_op     = ALU_SUB;
                    ext_op     = 1'b1;
                    npc_op     = NPC_BR;
                    pc_wr      = zero;
                    instr_done = 1'b1;
                end
                JMP: begin
                    pc_wr      = 1'b1;
                    instr_done = 1'b1;
                    case (cls)
                        CL_JR:  npc_op = NPC_JR;
                        CL_JAL: begin
                            npc_op  = NPC_J;
                            rf_wr   = 1'b1;
                            gpr_sel = GPR_RA;
                            wd_sel  = WD_PC;
                        end
                        default: npc_op = NPC_J;
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed-vector bench for mc_ctrl: one table row per clock cycle with
// hand-computed outputs, plus hand-written reset-in-the-middle sequences.
module tb_mc_ctrl;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_ORI   = 6'b001101;
    localparam logic [5:0] T_LUI   = 6'b001111;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_JAL   = 6'b000011;
    localparam logic [5:0] T_BAD   = 6'b111111;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_NONE  = 6'b000000;

    // Packed view: {pc_wr, ir_wr, rf_wr, dm_wr, ext_op, alu_op, b_sel, gpr_sel, wd_sel, npc_op, instr_done, illegal}
    localparam logic [15:0] PCW  = 16'h8000;
    localparam logic [15:0] IRW  = 16'h4000;
    localparam logic [15:0] RFW  = 16'h2000;
    localparam logic [15:0] DMW  = 16'h1000;
    localparam logic [15:0] EXT  = 16'h0800;
    localparam logic [15:0] BSEL = 16'h0100;
    localparam logic [15:0] DONE = 16'h0002;
    localparam logic [15:0] ILL  = 16'h0001;
    localparam logic [15:0] FET  = PCW | IRW;
    localparam logic [15:0] NONE = 16'h0000;

    function automatic logic [15:0] aluField(input logic [1:0] x);
        return {5'b0, x, 9'b0};
    endfunction
    function automatic logic [15:0] gprField(input logic [1:0] x);
        return {8'b0, x, 6'b0};
    endfunction
    function automatic logic [15:0] wdField(input logic [1:0] x);
        return {10'b0, x, 4'b0};
    endfunction
    function automatic logic [15:0] npcField(input logic [1:0] x);
        return {12'b0, x, 2'b0};
    endfunction

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [15:0] exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_wr;
    logic       ir_wr;
    logic       rf_wr;
    logic       dm_wr;
    logic       ext_op;
    logic [1:0] alu_op;
    logic       b_sel;
    logic [1:0] gpr_sel;
    logic [1:0] wd_sel;
    logic [1:0] npc_op;
    logic       instr_done;
    logic       illegal;

    vec_t vecs[$];
    int   nVec;
    int   nMis;

    mc_ctrl dut (
        .clk(clk),
        .rst(rst),
        .op(op),
        .funct(funct),
        .zero(zero),
        .pc_wr(pc_wr),
        .ir_wr(ir_wr),
        .rf_wr(rf_wr),
        .dm_wr(dm_wr),
        .ext_op(ext_op),
        .alu_op(alu_op),
        .b_sel(b_sel),
        .gpr_sel(gpr_sel),
        .wd_sel(wd_sel),
        .npc_op(npc_op),
        .instr_done(instr_done),
        .illegal(illegal)
    );

    // Free-running clock; rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic addVec(input string n, input logic r, input logic [5:0] o,
                          input logic [5:0] f, input logic z, input logic [15:0] e);
        vec_t v;
        v.name  = n;
        v.rst   = r;
        v.op    = o;
        v.funct = f;
        v.zero  = z;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic r, input logic [5:0] o,
                                 input logic [5:0] f, input logic z);
        @(negedge clk);
        rst   = r;
        op    = o;
        funct = f;
        zero  = z;
        #1;
    endtask

    task automatic checkOutput(input string n, input logic [15:0] e);
        logic [15:0] got;
        got = {pc_wr, ir_wr, rf_wr, dm_wr, ext_op, alu_op, b_sel,
               gpr_sel, wd_sel, npc_op, instr_done, illegal};
        nVec++;
        if (got !== e) begin
            nMis++;
            $display("[TB] FAIL %s: got %016b expected %016b (pc ir rf dm ext alu2 b gpr2 wd2 npc2 done ill)",
                     n, got, e);
        end
    endtask

    // Ordinary instruction flow, one row per cycle, starting from a reset cycle.
    initial begin
        nVec  = 0;
        nMis  = 0;
        rst   = 1'b1;
        op    = 6'b0;
        funct = 6'b0;
        zero  = 1'b0;

        addVec("reset",      1, T_LW,    F_NONE, 0, NONE);
        addVec("lw.fetch",   0, T_LW,    F_NONE, 0, FET);
        addVec("lw.dcd",     0, T_LW,    F_NONE, 0, NONE);
        addVec("lw.ma",      0, T_LW,    F_NONE, 0, EXT | BSEL | aluField(2'b00));
        addVec("lw.mr",      0, T_LW,    F_NONE, 0, NONE);
        addVec("lw.mwb",     0, T_LW,    F_NONE, 0, RFW | gprField(2'b00) | wdField(2'b01) | DONE);
        addVec("sw.fetch",   0, T_SW,    F_NONE, 0, FET);
        addVec("sw.dcd",     0, T_SW,    F_NONE, 0, NONE);
        addVec("sw.ma",      0, T_SW,    F_NONE, 0, EXT | BSEL);
        addVec("sw.mw",      0, T_SW,    F_NONE, 0, DMW | EXT | BSEL | DONE);
        addVec("addu.fetch", 0, T_RTYPE, F_ADDU, 0, FET);
        addVec("addu.dcd",   0, T_RTYPE, F_ADDU, 0, NONE);
        addVec("addu.exe",   0, T_RTYPE, F_ADDU, 0, NONE);
        addVec("addu.wb",    0, T_RTYPE, F_ADDU, 0, RFW | gprField(2'b01) | wdField(2'b00) | DONE);
        addVec("subu.fetch", 0, T_RTYPE, F_SUBU, 1, FET);
        addVec("subu.dcd",   0, T_RTYPE, F_SUBU, 1, NONE);
        addVec("subu.exe",   0, T_RTYPE, F_SUBU, 1, aluField(2'b01));
        addVec("subu.wb",    0, T_RTYPE, F_SUBU, 1, RFW | aluField(2'b01) | gprField(2'b01) | DONE);
        addVec("ori.fetch",  0, T_ORI,   F_NONE, 0, FET);
        addVec("ori.dcd",    0, T_ORI,   F_NONE, 0, NONE);
        addVec("ori.exe",    0, T_ORI,   F_NONE, 0, aluField(2'b10) | BSEL);
        addVec("ori.wb",     0, T_ORI,   F_NONE, 0, RFW | aluField(2'b10) | BSEL | DONE);
        addVec("lui.fetch",  0, T_LUI,   F_NONE, 0, FET);
        addVec("lui.dcd",    0, T_LUI,   F_NONE, 0, NONE);
        addVec("lui.exe",    0, T_LUI,   F_NONE, 0, aluField(2'b11) | BSEL);
        addVec("lui.wb",     0, T_LUI,   F_NONE, 0, RFW | aluField(2'b11) | BSEL | DONE);
        addVec("beq1.fetch", 0, T_BEQ,   F_NONE, 1, FET);
        addVec("beq1.dcd",   0, T_BEQ,   F_NONE, 1, NONE);
        addVec("beq1.br",    0, T_BEQ,   F_NONE, 1, PCW | aluField(2'b01) | EXT | npcField(2'b01) | DONE);
        addVec("beq0.fetch", 0, T_BEQ,   F_NONE, 0, FET);
        addVec("beq0.dcd",   0, T_BEQ,   F_NONE, 0, NONE);
        addVec("beq0.br",    0, T_BEQ,   F_NONE, 0, aluField(2'b01) | EXT | npcField(2'b01) | DONE);
        addVec("j.fetch",    0, T_J,     F_NONE, 0, FET);
        addVec("j.dcd",      0, T_J,     F_NONE, 0, NONE);
        addVec("j.jmp",      0, T_J,     F_NONE, 0, PCW | npcField(2'b10) | DONE);
        addVec("jal.fetch",  0, T_JAL,   F_NONE, 0, FET);
        addVec("jal.dcd",    0, T_JAL,   F_NONE, 0, NONE);
        addVec("jal.jmp",    0, T_JAL,   F_NONE, 0, PCW | npcField(2'b10) | RFW | gprField(2'b10) | wdField(2'b10) | DONE);
        addVec("jr.fetch",   0, T_RTYPE, F_JR,   0, FET);
        addVec("jr.dcd",     0, T_RTYPE, F_JR,   0, NONE);
        addVec("jr.jmp",     0, T_RTYPE, F_JR,   0, PCW | npcField(2'b11) | DONE);
        addVec("ill.fetch",  0, T_BAD,   F_NONE, 0, FET);
        addVec("ill.dcd",    0, T_BAD,   F_NONE, 0, ILL | DONE);
        addVec("illr.fetch", 0, T_RTYPE, F_NONE, 0, FET);
        addVec("illr.dcd",   0, T_RTYPE, F_NONE, 0, ILL | DONE);
        addVec("ill.next",   0, T_BAD,   F_NONE, 0, FET);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].zero);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Reset during MR of a lw: outputs vanish that cycle, then a fresh full lw.
        applyStimulus(1, T_LW, F_NONE, 0); checkOutput("rlw.sync",  NONE);
        applyStimulus(0, T_LW, F_NONE, 0); checkOutput("rlw.fetch", FET);
        applyStimulus(0, T_LW, F_NONE, 0); checkOutput("rlw.dcd",   NONE);
        applyStimulus(0, T_LW, F_NONE, 0); checkOutput("rlw.ma",    EXT | BSEL);
        applyStimulus(1, T_LW, F_NONE, 0); checkOutput("rlw.mr_rst", NONE);
        applyStimulus(0, T_LW, F_NONE, 0); checkOutput("rlw.refetch", FET);
        applyStimulus(0, T_LW, F_NONE, 0); checkOutput("rlw.dcd2",  NONE);
        applyStimulus(0, T_LW, F_NONE, 0); checkOutput("rlw.ma2",   EXT | BSEL);
        applyStimulus(0, T_LW, F_NONE, 0); checkOutput("rlw.mr2",   NONE);
        applyStimulus(0, T_LW, F_NONE, 0); checkOutput("rlw.mwb2",  RFW | wdField(2'b01) | DONE);

        // Reset in the MW cycle of a sw must suppress the memory write.
        applyStimulus(0, T_SW, F_NONE, 0); checkOutput("rsw.fetch", FET);
        applyStimulus(0, T_SW, F_NONE, 0); checkOutput("rsw.dcd",   NONE);
        applyStimulus(0, T_SW, F_NONE, 0); checkOutput("rsw.ma",    EXT | BSEL);
        applyStimulus(1, T_SW, F_NONE, 0); checkOutput("rsw.mw_rst", NONE);
        applyStimulus(0, T_SW, F_NONE, 0); checkOutput("rsw.refetch", FET);

        // Reset in the JMP cycle of a jal must suppress both PC and link writes.
        applyStimulus(0, T_JAL, F_NONE, 0); checkOutput("rjal.dcd",  NONE);
        applyStimulus(1, T_JAL, F_NONE, 0); checkOutput("rjal.jmp_rst", NONE);
        applyStimulus(0, T_JAL, F_NONE, 0); checkOutput("rjal.refetch", FET);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
